// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states and grant owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port backing memory between fetch (reads) and the data stage
// (reads/writes); data has priority, bounded by a fetch starvation counter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_ready,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             stall_F,
  output logic             stall_M
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_r;
  grant_t           grant_r;
  logic [CNT_W-1:0] starve_cnt_r;
  logic             i_ready_r;
  logic             d_ready_r;
  logic             mem_req_r;
  logic             mem_we_r;
  logic [WIDTH-1:0] mem_addr_r;
  logic [WIDTH-1:0] mem_wdata_r;
  logic [WIDTH-1:0] i_rdata_r;
  logic [WIDTH-1:0] d_rdata_r;

  logic             any_req_s;
  logic             pick_d_s;
  logic [CNT_W-1:0] starve_nxt_s;

  // Winner selection and the starvation count that goes with that grant.
  always_comb begin
    any_req_s    = i_req | d_req;
    pick_d_s     = 1'b0;
    starve_nxt_s = starve_cnt_r;
    if (d_req && !(i_req && (starve_cnt_r == LIMIT_C))) begin
      pick_d_s = 1'b1;
    end else begin
      pick_d_s = 1'b0;
    end
    if (!pick_d_s) begin
      starve_nxt_s = '0;
    end else if (i_req && (starve_cnt_r != LIMIT_C)) begin
      starve_nxt_s = starve_cnt_r + CNT_W'(1);
    end else begin
      starve_nxt_s = starve_cnt_r;
    end
  end

  // Transaction FSM: grant in IDLE, wait for memory in BUSY, pulse ready in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= GNT_I;
      starve_cnt_r <= '0;
      i_ready_r    <= 1'b0;
      d_ready_r    <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      i_rdata_r    <= '0;
      d_rdata_r    <= '0;
    end else begin
      i_ready_r <= 1'b0;
      d_ready_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            grant_r      <= pick_d_s ? GNT_D : GNT_I;
            starve_cnt_r <= starve_nxt_s;
            mem_req_r    <= 1'b1;
            mem_we_r     <= pick_d_s & d_we;
            mem_addr_r   <= pick_d_s ? d_addr : i_addr;
            if (pick_d_s && d_we) begin
              mem_wdata_r <= d_wdata;
            end
            state_r <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req_r <= 1'b0;
            if (grant_r == GNT_D) begin
              d_ready_r <= 1'b1;
              if (!mem_we_r) begin
                d_rdata_r <= mem_rdata;
              end
            end else begin
              i_ready_r <= 1'b1;
              i_rdata_r <= mem_rdata;
            end
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          mem_req_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign i_rdata   = i_rdata_r;
  assign i_ready   = i_ready_r;
  assign d_rdata   = d_rdata_r;
  assign d_ready   = d_ready_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign stall_F   = i_req & ~i_ready_r;
  assign stall_M   = d_req & ~d_ready_r;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one shared single-port backing memory between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the 5-stage pipeline. It replaces the separate instruction and data memories once the design moves to a unified memory. Data requests have priority, and a starvation counter guarantees forward progress for fetch. The block sequences each transaction through a small FSM and returns one-cycle ready pulses that the pipeline uses to release its stalls.

## Interface
Parameters:
- WIDTH, 32, data and address width
- STARVE_LIMIT, 4, maximum consecutive data grants while a fetch is pending; must be ≥1

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch read request; held high with i_addr stable until i_ready
- i_addr  in  WIDTH  fetch address
- i_rdata  out  WIDTH  fetch read data; valid when i_ready
- i_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held high with d_we/d_addr/d_wdata stable until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  WIDTH  data address
- d_wdata  in  WIDTH  write data
- d_rdata  out  WIDTH  data read data; valid when d_ready and the access was a read
- d_ready  out  1  one-cycle completion pulse for data
- mem_req  out  1  request to backing memory; held until mem_ready
- mem_we  out  1  write enable to memory
- mem_addr  out  WIDTH  latched address
- mem_wdata  out  WIDTH  latched write data
- mem_rdata  in  WIDTH  memory read data; valid with mem_ready
- mem_ready  in  1  memory completion, one cycle; ignored unless mem_req is high
- stall_F  out  1  i_req & ~i_ready
- stall_M  out  1  d_req & ~d_ready

## Operation
- FSM states IDLE, BUSY, DONE; reset state IDLE.
- IDLE, no request: remain in IDLE.
- IDLE, any request present:
  - Choose the winner and latch grant, mem_we, mem_addr and mem_wdata (write data latched only for data writes).
  - Go to BUSY.
- Priority: data wins when d_req is high, unless i_req is high and starve_cnt == STARVE_LIMIT; in that case fetch wins.
- starve_cnt:
  - Increments on a data grant made while i_req is high.
  - Clears to 0 on any fetch grant.
  - Unchanged on a data grant with i_req low.
  - Saturates at STARVE_LIMIT.
- BUSY:
  - mem_req = 1 and latched fields are driven.
  - On mem_ready: if the access is a read, capture mem_rdata into i_rdata or d_rdata (by grant); go to DONE.
- DONE:
  - Pulse the granted ready for exactly this cycle.
  - The other ready stays 0.
  - mem_req = 0; go to IDLE. No new grant is made in DONE.
- Data writes: d_ready pulses; d_rdata holds its previous value.
- Rdata registers hold their value between completions.
- mem_we, mem_addr and mem_wdata hold their last latched values outside BUSY. They are only meaningful while mem_req is high.
- Requests arriving during BUSY or DONE wait; they are sampled in the next IDLE cycle.

## Timing
- Reset values: state IDLE; mem_req, mem_we, i_ready, d_ready = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0; starve_cnt = 0.
- Minimum latency: request sampled in IDLE at cycle t → mem_req at t+1. If mem_ready arrives at t+1, ready pulses at t+2.
- General latency: ready = t + 2 + (mem_ready wait cycles beyond the first BUSY cycle).
- Back-to-back: the next grant happens no earlier than the IDLE cycle following DONE. Peak throughput is one transaction per 3 cycles.
- Simultaneous i_req and d_req in IDLE: data wins, except at the starvation limit as above.
- mem_ready in IDLE or DONE: ignored. There is no state change and no ready pulse.
- Reset mid-transaction:
  - Return to IDLE immediately; mem_req drops the next cycle.
  - No ready pulse is produced; starve_cnt clears.
  - The requester reissues the request.
- stall_F and stall_M are combinational from inputs and registered readies.

## Structure
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, BUSY, DONE}
  - grant_t enum {GNT_I, GNT_D}
- The starvation counter width is derived in the module as $clog2(STARVE_LIMIT+1).
- No sub-module: priority select, counter and FSM live in a single always_ff/always_comb pair.

## Test plan
- Single fetch:
  - Stimulus: i_addr=0x100, memory returns 0xDEADBEEF with 0 wait cycles.
  - Required: mem_req at t+1, i_ready=1 with i_rdata=0xDEADBEEF at t+2, d_ready=0 throughout.
- Data write with 3 wait cycles:
  - Stimulus: d_we=1, d_addr=0x200, d_wdata=0x12345678.
  - Required: mem_we=1, mem_addr=0x200 and mem_wdata=0x12345678 held for 4 BUSY cycles; d_ready pulses once; d_rdata unchanged.
- Contention:
  - Stimulus: i_req and d_req high together, STARVE_LIMIT=4, both held continuously with reissue.
  - Required: grant order D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each I grant.
- Stall release:
  - Stimulus: d_req held during a fetch transaction.
  - Required: stall_M=1 until the data ready; the data grant occurs in the IDLE cycle after the fetch DONE.
- Spurious mem_ready:
  - Stimulus: mem_ready pulsed while IDLE.
  - Required: no state change, no ready pulse.
- Reset mid-BUSY:
  - Stimulus: rst asserted during the second BUSY cycle of a data read.
  - Required: all outputs at reset values the next cycle, no d_ready; the reissued request completes normally.
